// File: rtl/upsample_stream_serializer.sv
// Captures one flat upsampled feature map in a single handshake and replays it
// element by element with column/row/channel position and row/map-end flags.
//
// state | meaning
// IDLE  | waiting for a map; in_ready high
// SEND  | streaming elements k = 0..N-1; out_valid high
module upsample_stream_serializer #(
  parameter  int DATA_WIDTH = 16,
  parameter  int H          = 2,
  parameter  int W          = 2,
  parameter  int D          = 1,
  localparam int OH         = 2 * H,
  localparam int OW         = 2 * W,
  localparam int N          = D * OH * OW,
  localparam int IW         = N * DATA_WIDTH,
  localparam int CW         = (OW > 1) ? $clog2(OW) : 1,
  localparam int RW         = (OH > 1) ? $clog2(OH) : 1,
  localparam int CHW        = (D > 1) ? $clog2(D) : 1,
  localparam int KW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IW-1:0]         in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         out_col,
  output logic [RW-1:0]         out_row,
  output logic [CHW-1:0]        out_ch,
  output logic                  out_eol,
  output logic                  out_last
);

  localparam logic [KW-1:0] K_MAX = KW'(N - 1);
  localparam logic [CW-1:0] C_MAX = CW'(OW - 1);
  localparam logic [RW-1:0] R_MAX = RW'(OH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] map_q [N];
  logic [KW-1:0]         k_q, k_d;
  logic [CW-1:0]         c_d;
  logic [RW-1:0]         r_d;
  logic [CHW-1:0]        ch_d;
  logic                  in_ready_d, out_valid_d, eol_d, last_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && in_ready) state_d = SEND;
      SEND:    if (out_ready && k_q == K_MAX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture     = (state_q == IDLE) && in_valid && in_ready;
    k_d         = k_q;
    c_d         = out_col;
    r_d         = out_row;
    ch_d        = out_ch;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    data_d      = out_data;
    eol_d       = out_eol;
    last_d      = out_last;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (capture) begin
          k_d         = '0;
          c_d         = '0;
          r_d         = '0;
          ch_d        = '0;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          data_d      = in_data[DATA_WIDTH-1:0];
          eol_d       = (C_MAX == '0);
          last_d      = (K_MAX == '0);
        end
      end
      SEND: begin
        if (out_ready) begin
          if (k_q == K_MAX) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            eol_d       = 1'b0;
            last_d      = 1'b0;
          end else begin
            k_d = k_q + KW'(1);
            // column wraps into row, row wraps into channel
            if (out_col == C_MAX) begin
              c_d = '0;
              if (out_row == R_MAX) begin
                r_d  = '0;
                ch_d = out_ch + CHW'(1);
              end else begin
                r_d = out_row + RW'(1);
              end
            end else begin
              c_d = out_col + CW'(1);
            end
            data_d = map_q[k_d];
            eol_d  = (c_d == C_MAX);
            last_d = (k_d == K_MAX);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q       <= '0;
      out_col   <= '0;
      out_row   <= '0;
      out_ch    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      k_q       <= k_d;
      out_col   <= c_d;
      out_row   <= r_d;
      out_ch    <= ch_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_data  <= data_d;
      out_eol   <= eol_d;
      out_last  <= last_d;
    end
  end

  // Map storage carries no reset: it is only read after a capture refills it.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N; i++) map_q[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule
